// File: rtl/id_scoreboard_pkg.sv
// Shared decode definitions for the ID-stage register scoreboard and the
// control unit: opcode/register types, counter sizing and operand-usage
// helpers.
package id_scoreboard_pkg;

  typedef logic [4:0] reg_addr_t;

  // RV32I major opcodes (instr[6:0]).
  typedef enum logic [6:0] {
    OP_LOAD           = 7'b0000011,
    OP_FENCE          = 7'b0001111,
    OP_ARITHMETIC_IMM = 7'b0010011,
    OP_AUIPC          = 7'b0010111,
    OP_STORE          = 7'b0100011,
    OP_ARITHMETIC_REG = 7'b0110011,
    OP_LUI            = 7'b0110111,
    OP_BRANCH         = 7'b1100011,
    OP_JALR           = 7'b1100111,
    OP_JAL            = 7'b1101111,
    OP_SYSTEM         = 7'b1110011
  } opcode_t;

  localparam int NUM_REGS = 32;

  // Counters are sized for the deepest legal MAX_PENDING (7), so one width
  // serves every instance regardless of the chosen depth.
  localparam int MAX_PENDING_LIMIT = 7;
  localparam int SB_CNT_W          = $clog2(MAX_PENDING_LIMIT + 1);

  function automatic logic uses_rs1(opcode_t op);
    return op inside {OP_LOAD, OP_STORE, OP_ARITHMETIC_IMM, OP_ARITHMETIC_REG,
                      OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic uses_rs2(opcode_t op);
    return op inside {OP_STORE, OP_ARITHMETIC_REG, OP_BRANCH};
  endfunction

  function automatic logic writes_rd(opcode_t op);
    return op inside {OP_LOAD, OP_ARITHMETIC_IMM, OP_ARITHMETIC_REG, OP_JAL,
                      OP_JALR, OP_AUIPC, OP_LUI};
  endfunction

endpackage

// File: rtl/id_scoreboard_entry.sv
// Per-register pending-write counter. One instance per architectural
// register x1..x31; x0 has no entry.
module sb_entry
  import id_scoreboard_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                inc_i,
  input  logic                wb_hit_i,
  output logic [SB_CNT_W-1:0] cnt_o,
  output logic                busy_o,
  output logic                underflow_o
);

  logic dec;

  // A writeback only retires a write that is actually outstanding; one that
  // finds the counter empty is reported instead of wrapping.
  assign dec         = wb_hit_i && (cnt_o != '0);
  assign underflow_o = wb_hit_i && (cnt_o == '0);
  assign busy_o      = (cnt_o != '0);

  // Count issues up and retirements down; simultaneous inc/dec cancel.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (inc_i && !dec) begin
      cnt_o <= cnt_o + SB_CNT_W'(1);
    end else if (dec && !inc_i) begin
      cnt_o <= cnt_o - SB_CNT_W'(1);
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// Register scoreboard and issue controller for the ID stage.
// Tracks in-flight register writes, gates issue on RAW hazards and
// pending-write overflow, and keeps a sticky error flag plus a saturating
// stall-cycle counter for debug.
// Optional feature macro: SB_FORWARD_EN -- when defined, only LOAD
// destinations are tracked (other results are covered by forwarding).
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int MAX_PENDING = 3,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   id_valid_i,
  output logic                   id_ready_o,
  input  opcode_t                op_i,
  input  reg_addr_t              rd_i,
  input  reg_addr_t              rs1_i,
  input  reg_addr_t              rs2_i,
  input  logic                   flush_i,
  input  logic                   wb_valid_i,
  input  reg_addr_t              wb_rd_i,
  output logic [31:0]            busy_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   sb_err_o
);

  logic [SB_CNT_W-1:0] cnt [NUM_REGS];
  logic [SB_CNT_W-1:0] eff [NUM_REGS];
  logic [31:0]         busy_vec;
  logic [31:0]         underflow_vec;
  logic                rd_tracked;
  logic                raw_hazard;
  logic                waw_overflow;
  logic                fire;
  logic                stall_event;

`ifdef SB_FORWARD_EN
  // ALU/jump/upper-immediate results are forwarded; only loads need tracking.
  assign rd_tracked = writes_rd(op_i) && (op_i == OP_LOAD);
`else
  assign rd_tracked = writes_rd(op_i);
`endif

  // Per-register counters; x0 is hard-wired empty.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    if (r == 0) begin : g_x0
      assign cnt[r]           = '0;
      assign busy_vec[r]      = 1'b0;
      assign underflow_vec[r] = 1'b0;
    end else begin : g_reg
      sb_entry u_entry (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (fire && rd_tracked && (rd_i == reg_addr_t'(r))),
        .wb_hit_i    (wb_valid_i && (wb_rd_i == reg_addr_t'(r))),
        .cnt_o       (cnt[r]),
        .busy_o      (busy_vec[r]),
        .underflow_o (underflow_vec[r])
      );
    end
  end

  // Effective counts: a writeback this cycle is already visible to ID.
  // NOTE: always_comb assigns a default before any conditional update so no
  // path leaves a value held, which would infer a latch.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      eff[r] = cnt[r];
      if (wb_valid_i && (wb_rd_i == reg_addr_t'(r)) && (cnt[r] != '0)) begin
        eff[r] = cnt[r] - SB_CNT_W'(1);
      end
    end
  end

  assign raw_hazard   = (uses_rs1(op_i) && (rs1_i != '0) && (eff[rs1_i] != '0)) ||
                        (uses_rs2(op_i) && (rs2_i != '0) && (eff[rs2_i] != '0));
  assign waw_overflow = rd_tracked && (rd_i != '0) &&
                        (eff[rd_i] == SB_CNT_W'(MAX_PENDING));

  assign id_ready_o  = !(raw_hazard || waw_overflow);
  assign fire        = id_valid_i && id_ready_o && !flush_i;
  assign stall_event = id_valid_i && !id_ready_o && !flush_i;
  assign busy_o      = busy_vec;

  // Saturating count of cycles a valid, unflushed instruction was held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
    end else if (stall_event && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
    end
  end

  // Sticky flag for a writeback that found no outstanding write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_err_o <= 1'b0;
    end else if (|underflow_vec) begin
      sb_err_o <= 1'b1;
    end
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register scoreboard and issue controller for the decode stage of the 5-stage RV32I pipeline. It tracks which architectural registers have writes in flight between ID and writeback. It holds the decoded instruction in ID (valid/ready) until its source operands and destination are hazard-free. It also keeps a sticky error flag and a saturating stall-cycle counter for debug.

## Interface
Parameters:
- MAX_PENDING, 3: max in-flight writes tracked per register (1..7).
- STALL_CNT_W, 32: width of stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- id_valid_i  in  1  ID holds a decoded instruction.
- id_ready_o  out  1  instruction may issue this cycle.
- op_i  in  opcode_t  decoded opcode.
- rd_i, rs1_i, rs2_i  in  reg_addr_t  decoded register indices.
- flush_i  in  1  branch/jump redirect; squashes the instruction in ID.
- wb_valid_i  in  1  writeback stage retires a register write.
- wb_rd_i  in  reg_addr_t  writeback destination.
- busy_o  out  32  bit r set when register r has pending count > 0; bit 0 always 0.
- stall_cnt_o  out  STALL_CNT_W  stall cycles since reset.
- sb_err_o  out  1  sticky: writeback to a register with count 0.

## Operation
- Usage by opcode:
  - rs1 used: LOAD, STORE, ARITHMETIC_IMM, ARITHMETIC_REG, BRANCH, JALR.
  - rs2 used: STORE, ARITHMETIC_REG, BRANCH.
  - rd written: LOAD, ARITHMETIC_IMM, ARITHMETIC_REG, JAL, JALR, AUIPC, LUI.
  - Any other opcode: uses nothing, writes nothing.
- Register x0 is never tracked. Its count stays 0, and reads/writes of x0 never create hazards.
- Effective count of r = cnt[r] − (wb_valid_i && wb_rd_i==r && cnt[r]>0). This is the same-cycle writeback bypass.
- RAW hazard: a used rs has effective count > 0.
- WAW overflow: rd written and effective count of rd == MAX_PENDING.
- id_ready_o = !(RAW hazard || WAW overflow). It does not depend on flush_i or id_valid_i.
- fire = id_valid_i && id_ready_o && !flush_i.
- Per-register update each cycle: +1 if fire writes r; −1 if a writeback to r hits a nonzero count. Both in the same cycle → unchanged.
- Writeback to r with cnt[r]==0 (r≠0): count unchanged, sb_err_o set until reset.
- stall_cnt_o increments when id_valid_i && !id_ready_o && !flush_i, and saturates at all-ones.

## Timing
- Reset values:
  - all counts 0
  - busy_o 0
  - stall_cnt_o 0
  - sb_err_o 0
  - id_ready_o 1
- id_ready_o is combinational from registered counts plus the current ID/WB inputs (zero-cycle decision).
- Issue at edge N is reflected in busy_o after edge N, so the next instruction sees it.
- Writeback in cycle N unblocks a dependent instruction in the same cycle N.
- flush_i in the same cycle as a would-be issue: no count change, no stall count, and the instruction is discarded.
- Reset mid-operation clears all state asynchronously; in-flight writebacks after reset that hit count 0 set sb_err_o. Upstream reset is coincident, so this is not expected.

## Configuration
- SB_FORWARD_EN defined: only LOAD destinations are tracked, because the EX/MEM forwarding network covers ALU, JAL, JALR, AUIPC and LUI results. Other write opcodes issue without counting. The writeback port is driven only for loads.
- SB_FORWARD_EN undefined: every rd-writing opcode is tracked (no-forwarding pipeline).

## Structure
- Additions to the defs package:
  - SB_CNT_W = $clog2(MAX_PENDING+1)
  - functions uses_rs1(opcode_t), uses_rs2(opcode_t), writes_rd(opcode_t), shared with the control unit.
- Sub-module sb_entry: one per register x1–x31, generated. It holds the per-register count and its inc/dec, and outputs the count, busy and underflow signals. Top level does hazard compare, handshake, stall counter and error flag.

## Test plan
- Reset, then ADD x3,x1,x2 valid → id_ready_o=1 and busy_o=32'h8 after the edge. Following ADD x4,x3,x3 → id_ready_o=0 until wb_valid_i with wb_rd_i=3, when id_ready_o=1 in the same cycle.
- LW x5 issued; ADDI x6,x5,1 waits 3 cycles → stall_cnt_o=3; with SB_FORWARD_EN, ADD x7 issue leaves bit 7 clear.
- Three ADDI x8 issued (MAX_PENDING=3), fourth stalls; one writeback to x8 with the fourth valid → fourth issues and count stays 3.
- Hazarded instruction valid with flush_i=1 → counts and stall_cnt_o unchanged; writeback to x9 with count 0 → sb_err_o=1 and stays 1.
- Instruction with rd=x0 or rs=x0 → never stalls, busy_o[0]=0. Assert rst_ni low mid-stream → all outputs return to reset values immediately.
